note_scheduler: RTL
===================

NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 2_000_000, meaning clk cycles one note sounds per round-robin slot.
REQ-002 SHALL have parameter GAP_CYCLES, default 50_000, meaning silent clk cycles between consecutive slots (used only when the gap feature is compiled in).
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous to clk and active-high.
REQ-005 SHALL have port req_notes  input  9 (Notes)  requested notes: [6:0] note keys, [7] octave up, [8] octave down.
REQ-006 SHALL have port play_notes  output  9 (Notes)  drive to audio output, with at most one bit of [6:0] set.
REQ-007 SHALL have port voice_idx  output  3  index 0-6 of the sounding note, 3'd7 when silent.
REQ-008 SHALL have port slot_start  output  1  one-cycle pulse on the first cycle of each PLAY slot.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, SELECT, PLAY and GAP; all outputs registered.
REQ-011 IDLE: outputs silent; on req_notes[6:0]!=0 go to SELECT next cycle.
REQ-012 SELECT (1 cycle): pick the first set bit of req_notes[6:0] searching upward from (last_idx+1) mod 7, wrapping 6->0, with last_idx included last; go to PLAY; if no bit is set, go to IDLE.
REQ-013 On entry to PLAY: latch the note into play_notes and voice_idx; latch the octave bits; assert slot_start for that cycle; load the slot counter.
REQ-014 Latency: a request arriving while IDLE at edge t SHALL produce valid play_notes after edge t+2.
REQ-015 Octave: if both req_notes[7] and [8] are set, octave up SHALL win ([8] forced 0); octave changes apply only at the next SELECT.
REQ-016 PLAY SHALL last exactly SLOT_CYCLES cycles, then go to GAP, or to SELECT when the gap feature is absent.
REQ-017 If the latched note bit drops during PLAY, the slot SHALL end on the next cycle as if expired.
REQ-018 When exactly one note is held and it equals the current note at slot expiry, the block SHALL skip GAP, reload PLAY, and not pulse slot_start, so the tone is continuous.
REQ-019 GAP: outputs silent with voice_idx=7 for GAP_CYCLES, then go to SELECT.
REQ-020 If req_notes[6:0]==0 in any state, the block SHALL go to IDLE next cycle.
REQ-021 Counters SHALL be wide enough for max(SLOT_CYCLES, GAP_CYCLES) with no wrap; parameter values below 1 SHALL be a compile-time error.

Reset
REQ-022 sys_rst SHALL set state=IDLE, play_notes=0, voice_idx=7, slot_start=0, busy=0, last_idx=6 (so the first pick searches from 0) and counters=0.
REQ-023 sys_rst asserted mid-PLAY or mid-GAP SHALL take effect at the next clk edge and override all other transitions.

Configuration
REQ-024 Macro NOTE_SCHED_GAP_EN: when defined, the GAP state and GAP_CYCLES are implemented; when undefined, GAP logic is removed, PLAY expiry goes directly to SELECT, and GAP_CYCLES is ignored.

Structure
REQ-025 The SchedState enum and the NO_VOICE=3'd7 constant SHALL live in the shared header/package alongside Notes.
REQ-026 The round-robin search SHALL be a combinational sub-module rr_note_picker (inputs: 7-bit request, 3-bit last index; outputs: 3-bit index, valid).

Verification (SLOT_CYCLES=8, GAP_CYCLES=2, GAP_EN defined)
REQ-027 Reset, then req_notes=9'h001 at t -> play_notes=9'h001 after t+2 and held continuously with no silence for 40 cycles; slot_start pulses once.
REQ-028 req_notes=9'h00A -> voice_idx sequence 1,3,1,3 with each note lasting 8 cycles and 2 silent cycles (voice_idx=7) between slots.
REQ-029 Note 3 playing, notes {0,6} also held -> next pick 6 and then 0, proving the wrap from 6 to 0.
REQ-030 req_notes=9'h184 -> play_notes=9'h084 (octave up wins); change to 9'h104 mid-slot -> new octave appears only at the next slot.
REQ-031 Release the playing note at PLAY cycle 3 -> GAP next cycle; release all notes -> IDLE, busy=0, voice_idx=7.
REQ-032 Assert sys_rst mid-PLAY -> all outputs at reset values after the next edge; with GAP_EN undefined, two notes alternate with no silent cycles.

Source files
------------

// File: rtl/note_scheduler_pkg.sv
// Shared types for the note scheduler: note bus layout, FSM states, voice constants.
package note_scheduler_pkg;

  localparam int unsigned NUM_KEYS = 7;
  localparam int unsigned VOICE_W  = 3;

  localparam logic [VOICE_W-1:0] NO_VOICE = 3'd7;

  typedef struct packed {
    logic                oct_down;
    logic                oct_up;
    logic [NUM_KEYS-1:0] keys;
  } notes_t;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    PLAY,
    GAP
  } sched_state_e;

endpackage

// File: rtl/note_scheduler_picker.sv
// Combinational round-robin picker: first set key searching upward from last_idx+1, wrapping, last_idx checked last.
module rr_note_picker
  import note_scheduler_pkg::*;
(
  input  logic [NUM_KEYS-1:0] req,
  input  logic [VOICE_W-1:0]  last_idx,
  output logic [VOICE_W-1:0]  idx,
  output logic                valid
);

  logic [VOICE_W-1:0] start;
  logic [VOICE_W:0]   pos;

  always_comb begin
    start = (last_idx >= VOICE_W'(NUM_KEYS - 1)) ? '0 : last_idx + VOICE_W'(1);
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      pos = {1'b0, start} + (VOICE_W+1)'(k);
      if (pos >= (VOICE_W+1)'(NUM_KEYS)) begin
        pos = pos - (VOICE_W+1)'(NUM_KEYS);
      end
      if (!valid && req[pos[VOICE_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[VOICE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Round-robin note scheduler: time-slices held keys onto a single audible voice.
// Define NOTE_SCHED_GAP_EN to insert a silent gap of GAP_CYCLES between slots.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int SLOT_CYCLES = 2_000_000,
  parameter int GAP_CYCLES  = 50_000
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  notes_t             req_notes,
  output notes_t             play_notes,
  output logic [VOICE_W-1:0] voice_idx,
  output logic               slot_start,
  output logic               busy
);

  if (SLOT_CYCLES < 1) begin : g_bad_slot
    $error("note_scheduler: SLOT_CYCLES must be at least 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("note_scheduler: GAP_CYCLES must be at least 1");
  end

`ifdef NOTE_SCHED_GAP_EN
  localparam int unsigned CNT_MAX = (SLOT_CYCLES > GAP_CYCLES) ? int'(SLOT_CYCLES) : int'(GAP_CYCLES);
`else
  localparam int unsigned CNT_MAX = SLOT_CYCLES;
`endif
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SLOT_CYCLES - 1);
`ifdef NOTE_SCHED_GAP_EN
  // The SELECT cycle that follows GAP is also silent, so GAP itself is one cycle shorter.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0);
`endif

  sched_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VOICE_W-1:0] last_idx_q, last_idx_d;
  notes_t             play_q, play_d;
  logic [VOICE_W-1:0] voice_q, voice_d;
  logic               slot_start_q, slot_start_d;
  logic               busy_q, busy_d;

  logic               any_req;
  logic               cur_held;
  logic               same_tone;
  logic               req_oct_down;
  logic [VOICE_W-1:0] pick_idx;
  logic               pick_valid;

  rr_note_picker u_picker (
    .req      (req_notes.keys),
    .last_idx (last_idx_q),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  // Octave up wins when both octave bits are requested.
  assign req_oct_down = req_notes.oct_down & ~req_notes.oct_up;
  assign any_req      = |req_notes.keys;
  assign cur_held     = |(req_notes.keys & play_q.keys);
  // Only the playing key is held and its octave is unchanged: keep the tone running.
  assign same_tone    = (req_notes.keys == play_q.keys)
                        && (req_notes.oct_up == play_q.oct_up)
                        && (req_oct_down == play_q.oct_down);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_idx_d   = last_idx_q;
    play_d       = play_q;
    voice_d      = voice_q;
    slot_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (pick_valid) begin
          state_d         = PLAY;
          play_d.keys     = NUM_KEYS'(1) << pick_idx;
          play_d.oct_up   = req_notes.oct_up;
          play_d.oct_down = req_oct_down;
          voice_d         = pick_idx;
          last_idx_d      = pick_idx;
          slot_start_d    = 1'b1;
          cnt_d           = SLOT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        if (!cur_held || (cnt_q == '0)) begin
          if (same_tone) begin
            cnt_d = SLOT_LOAD;
          end else begin
`ifdef NOTE_SCHED_GAP_EN
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            play_d  = '0;
            voice_d = NO_VOICE;
`else
            state_d = SELECT;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef NOTE_SCHED_GAP_EN
      GAP: begin
        if (cnt_q == '0) begin
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Releasing every key silences the block from any state.
    if (!any_req) begin
      state_d      = IDLE;
      cnt_d        = '0;
      play_d       = '0;
      voice_d      = NO_VOICE;
      slot_start_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_idx_q   <= VOICE_W'(NUM_KEYS - 1);
      play_q       <= '0;
      voice_q      <= NO_VOICE;
      slot_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_idx_q   <= last_idx_d;
      play_q       <= play_d;
      voice_q      <= voice_d;
      slot_start_q <= slot_start_d;
      busy_q       <= busy_d;
    end
  end

  assign play_notes = play_q;
  assign voice_idx  = voice_q;
  assign slot_start = slot_start_q;
  assign busy       = busy_q;

endmodule
